tt_um_jimktrains_vslc_servo_cfg: RTL

Serial configuration front-end for the VSLC servo PWM stage. It receives 24-bit configuration frames over a synchronously oversampled 3-wire serial link, validates them, and holds them in a staging register. It then commits them glitch-free to the servo generator's `servo_set_val`, `servo_reset_val`, `servo_freq_val` and `servo_enabled` inputs. Commit happens either at a PWM period boundary or immediately when the servo is disabled.

---
 rtl/vslc_servo_pkg.sv | 48 ++++
 rtl/vslc_sync_edge.sv | 33 +++
 rtl/tt_um_jimktrains_vslc_servo_cfg.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/vslc_servo_pkg.sv
// Shared definitions for the VSLC servo configuration front-end:
// frame layout, command code, FSM states and reset constants.
package vslc_servo_pkg;

    localparam int FRAME_BITS = 24;
    localparam logic [3:0] CMD_WRITE = 4'hA;

    // Frame field offsets and widths (bit 23 arrives first)
    localparam int CMD_LSB  = 20;
    localparam int CMD_W    = 4;
    localparam int RSV_BIT  = 19;
    localparam int EN_BIT   = 18;
    localparam int SET_LSB  = 13;
    localparam int SET_W    = 5;
    localparam int RST_LSB  = 8;
    localparam int RST_W    = 5;
    localparam int FREQ_LSB = 0;
    localparam int FREQ_W   = 8;

    // Bit counter saturates one above a full frame so overlong frames are rejected
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_CHECK   = 2'd2,
        ST_PENDING = 2'd3
    } state_t;

    typedef struct packed {
        logic              en;
        logic [SET_W-1:0]  set;
        logic [RST_W-1:0]  rst;
        logic [FREQ_W-1:0] freq;
    } cfg_t;

    localparam cfg_t   CFG_RST = '0;
    localparam state_t ST_RST  = ST_IDLE;

    // A threshold is usable only if the servo counter actually reaches it
    function automatic logic below_freq(input logic [SET_W-1:0] thr,
                                        input logic [FREQ_W-1:0] freq);
        return ({{(FREQ_W-SET_W){1'b0}}, thr} < freq);
    endfunction

endpackage

// File: rtl/vslc_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, plus a third flop
// used only to detect rising and falling edges of the synchronized value.
module vslc_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1, r_s2, r_s3;

    // Metastability chain followed by the edge-detect history flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
            r_s3 <= RST_VAL;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_sync = r_s2;
    assign o_rise = r_s2 & ~r_s3;
    assign o_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/tt_um_jimktrains_vslc_servo_cfg.sv
// Serial configuration front-end for the VSLC servo PWM stage.
// Receives 24-bit frames over an oversampled 3-wire link, validates them
// into a staging register and commits them to the servo outputs either at
// a PWM period boundary or at once while the servo is disabled.
module tt_um_jimktrains_vslc_servo_cfg
    import vslc_servo_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_cs_n,
    input  logic       cfg_sck,
    input  logic       cfg_sdi,
    input  logic       period_sync,
    output logic [4:0] servo_set_val,
    output logic [4:0] servo_reset_val,
    output logic [7:0] servo_freq_val,
    output logic       servo_enabled,
    output logic       cfg_pending,
    output logic       cfg_err
);

    logic w_cs_sync, w_cs_rise, w_cs_fall;
    logic w_sck_sync, w_sck_rise, w_sck_fall;
    logic w_unused_edges;

    logic r_sdi_s1, r_sdi_s2;

    state_t r_state, w_state_nxt;
    logic   r_from_pend, w_from_pend_nxt;

    logic [FRAME_BITS-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;

    cfg_t r_stage;
    cfg_t r_out;
    cfg_t w_frame_cfg;
    logic r_err;

    logic [CMD_W-1:0] w_cmd;
    logic             w_rsv;
    logic             w_frame_ok;
    logic             w_commit_cond;
    logic             w_commit, w_load, w_reject, w_clear, w_shift;

    // cs_n idles high, so its synchronizer resets high to avoid a false frame start
    vslc_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk     (clk),
        .rst     (rst),
        .i_async (cfg_cs_n),
        .o_sync  (w_cs_sync),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    vslc_sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
        .clk     (clk),
        .rst     (rst),
        .i_async (cfg_sck),
        .o_sync  (w_sck_sync),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    assign w_unused_edges = w_cs_sync ^ w_sck_sync ^ w_sck_fall;

    // sdi needs no edge detect; same depth as sck keeps it aligned with the detected rise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sdi_s1 <= 1'b0;
            r_sdi_s2 <= 1'b0;
        end else begin
            r_sdi_s1 <= cfg_sdi;
            r_sdi_s2 <= r_sdi_s1;
        end
    end

    // Field decode of the shifted frame
    assign w_cmd            = r_shift[CMD_LSB +: CMD_W];
    assign w_rsv            = r_shift[RSV_BIT];
    assign w_frame_cfg.en   = r_shift[EN_BIT];
    assign w_frame_cfg.set  = r_shift[SET_LSB +: SET_W];
    assign w_frame_cfg.rst  = r_shift[RST_LSB +: RST_W];
    assign w_frame_cfg.freq = r_shift[FREQ_LSB +: FREQ_W];

    assign w_frame_ok = (r_cnt == CNT_FULL) &&
                        (w_cmd == CMD_WRITE) &&
                        !w_rsv &&
                        (w_frame_cfg.freq != '0) &&
                        below_freq(w_frame_cfg.set, w_frame_cfg.freq) &&
                        below_freq(w_frame_cfg.rst, w_frame_cfg.freq);

    // A disabled servo has no period to protect, so it may be updated at once
    assign w_commit_cond = period_sync | ~r_out.en;

    // State and remembered-pending registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RST;
            r_from_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_from_pend <= w_from_pend_nxt;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        w_state_nxt     = r_state;
        w_from_pend_nxt = r_from_pend;
        w_commit        = 1'b0;
        w_load          = 1'b0;
        w_reject        = 1'b0;
        w_clear         = 1'b0;
        w_shift         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt     = ST_SHIFT;
                    w_clear         = 1'b1;
                    w_from_pend_nxt = 1'b0;
                end
            end
            ST_SHIFT: begin
                w_shift = w_sck_rise;
                if (r_from_pend && w_commit_cond) begin
                    w_commit        = 1'b1;
                    w_from_pend_nxt = 1'b0;
                end
                if (w_cs_rise) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // The older staged frame commits before the new one overwrites staging
                w_commit        = r_from_pend & w_commit_cond;
                w_from_pend_nxt = 1'b0;
                if (w_frame_ok) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_PENDING;
                end else begin
                    w_reject    = 1'b1;
                    w_state_nxt = (r_from_pend && !w_commit_cond) ? ST_PENDING : ST_IDLE;
                end
            end
            ST_PENDING: begin
                w_commit = w_commit_cond;
                if (w_cs_fall) begin
                    w_state_nxt     = ST_SHIFT;
                    w_clear         = 1'b1;
                    w_from_pend_nxt = ~w_commit_cond;
                end else if (w_commit_cond) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_from_pend_nxt = 1'b0;
            end
        endcase
    end

    // Serial shift register and saturating bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_shift) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], r_sdi_s2};
            if (r_cnt != CNT_SAT) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Staging register holds the last accepted frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage <= CFG_RST;
        end else if (w_load) begin
            r_stage <= w_frame_cfg;
        end
    end

    // Active outputs change as one word so the servo never sees a mixed setting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= CFG_RST;
        end else if (w_commit) begin
            r_out <= r_stage;
        end
    end

    // Sticky error reflects the outcome of the most recent frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_load) begin
            r_err <= 1'b0;
        end else if (w_reject) begin
            r_err <= 1'b1;
        end
    end

    assign servo_set_val   = r_out.set;
    assign servo_reset_val = r_out.rst;
    assign servo_freq_val  = r_out.freq;
    assign servo_enabled   = r_out.en;
    assign cfg_err         = r_err;
    assign cfg_pending     = (r_state == ST_PENDING) ||
                             (r_from_pend && ((r_state == ST_SHIFT) || (r_state == ST_CHECK)));

endmodule
